// File: rtl/arcabuco_muldiv.sv
// Multi-cycle integer multiply/divide unit with a valid/ready request and response handshake.
// Multiplies run through a short product pipeline; divides use a 32-step restoring divider.
module arcabuco_muldiv #(
  parameter int MUL_STAGES = 2,
  parameter bit HAVE_MUL   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        kill_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] result_o
);

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7
  } t_muldiv_opcode;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The first product stage is loaded at acceptance, so MUL_STAGES-1 registers remain.
  localparam int         PD       = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam logic [4:0] MUL_LAST = 5'(PD - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  function automatic logic [63:0] mul_full(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [32:0] ea;
    logic signed [32:0] eb;
    logic signed [63:0] p;
    ea = $signed({(op != OP_MULHU) & a[31], a});
    eb = $signed({((op == OP_MUL) || (op == OP_MULH)) & b[31], b});
    p  = ea * eb;
    return p;
  endfunction

  function automatic logic [31:0] mul_sel(input logic [3:0] op, input logic [63:0] p);
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mag(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic        ready_r;
  logic        resp_valid_r;
  logic [31:0] result_r;
  logic [3:0]  op_r;
  logic [4:0]  cnt_r;
  logic [63:0] mul_pipe_r [PD];
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic        neg_q_r;
  logic        neg_r_r;

  logic        accept_s;
  logic        is_mul_s;
  logic        is_div_s;
  logic        signed_div_s;
  logic        div_zero_s;
  logic        ovf_s;
  logic        special_s;
  logic [31:0] special_res_s;
  logic [32:0] sh_s;
  logic        ge_s;
  logic [31:0] rem_nx_s;
  logic [31:0] quo_nx_s;
  logic [31:0] div_res_s;

  assign req_ready_o  = ready_r & rst_ni;
  assign resp_valid_o = resp_valid_r;
  assign result_o     = result_r;
  assign accept_s     = req_valid_i & ready_r & ~kill_i;

  // Request decode: opcode class plus the results that need no iteration.
  always_comb begin
    is_mul_s      = HAVE_MUL && (op_i[3:2] == 2'b00);
    is_div_s      = (op_i[3:2] == 2'b01);
    signed_div_s  = is_div_s && !op_i[0];
    div_zero_s    = is_div_s && (b_i == 32'd0);
    ovf_s         = signed_div_s && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    special_s     = !(is_mul_s || is_div_s) || div_zero_s || ovf_s;
    special_res_s = 32'd0;
    if (div_zero_s) begin
      special_res_s = op_i[1] ? a_i : 32'hFFFF_FFFF;
    end else if (ovf_s) begin
      special_res_s = op_i[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      special_res_s = 32'd0;
    end
  end

  // One restoring-division step, with sign fix-up applied to the final step's values.
  always_comb begin
    sh_s      = {rem_r, quo_r[31]};
    ge_s      = (sh_s >= {1'b0, dvs_r});
    rem_nx_s  = ge_s ? (sh_s[31:0] - dvs_r) : sh_s[31:0];
    quo_nx_s  = {quo_r[30:0], ge_s};
    div_res_s = op_r[1] ? mag(neg_r_r, rem_nx_s) : mag(neg_q_r, quo_nx_s);
  end

  // Next-state logic; kill overrides every other transition.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (special_s) begin
            state_s = S_DONE;
          end else if (is_mul_s) begin
            state_s = (MUL_STAGES == 1) ? S_DONE : S_MUL;
          end else begin
            state_s = S_DIV;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_r == MUL_LAST) state_s = S_DONE;
        else                   state_s = S_MUL;
      end
      S_DIV: begin
        if (cnt_r == DIV_LAST) state_s = S_DONE;
        else                   state_s = S_DIV;
      end
      S_DONE: begin
        if (resp_ready_i) state_s = S_IDLE;
        else              state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
    if (kill_i) begin
      state_s = S_IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= S_IDLE;
    else         state_r <= state_s;
  end

  // Operand capture, multiply pipeline, divider iteration and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      result_r     <= 32'd0;
      op_r         <= 4'd0;
      cnt_r        <= 5'd0;
      quo_r        <= 32'd0;
      rem_r        <= 32'd0;
      dvs_r        <= 32'd0;
      neg_q_r      <= 1'b0;
      neg_r_r      <= 1'b0;
      for (int i = 0; i < PD; i++) mul_pipe_r[i] <= 64'd0;
    end else begin
      ready_r <= (state_s == S_IDLE);
      if (kill_i) begin
        resp_valid_r <= 1'b0;
        result_r     <= 32'd0;
        cnt_r        <= 5'd0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (accept_s) begin
              op_r  <= op_i;
              cnt_r <= 5'd0;
              if (special_s) begin
                result_r     <= special_res_s;
                resp_valid_r <= 1'b1;
              end else if (is_mul_s) begin
                mul_pipe_r[0] <= mul_full(op_i, a_i, b_i);
                if (MUL_STAGES == 1) begin
                  result_r     <= mul_sel(op_i, mul_full(op_i, a_i, b_i));
                  resp_valid_r <= 1'b1;
                end
              end else begin
                quo_r   <= mag(signed_div_s & a_i[31], a_i);
                dvs_r   <= mag(signed_div_s & b_i[31], b_i);
                rem_r   <= 32'd0;
                neg_q_r <= signed_div_s & (a_i[31] ^ b_i[31]);
                neg_r_r <= signed_div_s & a_i[31];
              end
            end
          end
          S_MUL: begin
            for (int i = 1; i < PD; i++) mul_pipe_r[i] <= mul_pipe_r[i-1];
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == MUL_LAST) begin
              result_r     <= mul_sel(op_r, mul_pipe_r[PD-1]);
              resp_valid_r <= 1'b1;
            end
          end
          S_DIV: begin
            quo_r <= quo_nx_s;
            rem_r <= rem_nx_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == DIV_LAST) begin
              result_r     <= div_res_s;
              resp_valid_r <= 1'b1;
            end
          end
          S_DONE: begin
            if (resp_ready_i) begin
              resp_valid_r <= 1'b0;
              result_r     <= 32'd0;
            end
          end
          default: begin
            resp_valid_r <= 1'b0;
            result_r     <= 32'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/arcabuco_muldiv.md
ARCABUCO_MULDIV -- requirements
Module: arcabuco_muldiv

Interface
REQ-001 The block SHALL have parameter MUL_STAGES, default 2, the multiply latency in cycles from request acceptance to response valid; legal range 1-4.
REQ-002 The block SHALL have parameter HAVE_MUL, default 1'b1; when 0, all multiply opcodes SHALL be treated as invalid opcodes.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid_i, input, 1 bit: the core presents an operation.
REQ-006 The block SHALL have port req_ready_o, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have port op_i, input, 4 bits: t_muldiv_opcode (mul=0, mulh=1, mulhsu=2, mulhu=3, div=4, divu=5, rem=6, remu=7); values 8-15 are invalid.
REQ-008 The block SHALL have ports a_i and b_i, inputs, 32 bits each: rs1 and rs2 operands.
REQ-009 The block SHALL have port kill_i, input, 1 bit: pipeline flush that aborts any in-flight operation.
REQ-010 The block SHALL have port resp_valid_o, output, 1 bit: result_o is valid.
REQ-011 The block SHALL have port resp_ready_i, input, 1 bit: the core consumes the result.
REQ-012 The block SHALL have port result_o, output, 32 bits: the operation result.

Function
REQ-013 Acceptance SHALL occur in cycle T when req_valid_i and req_ready_o are both high; op_i, a_i and b_i SHALL be captured at that edge.
REQ-014 FSM states SHALL be IDLE, MUL, DIV and DONE; req_ready_o SHALL be high only in IDLE, so at most one operation is in flight.
REQ-015 IDLE transitions on acceptance: multiply goes to MUL; divide or remainder goes to DIV; special cases (REQ-019, REQ-020) and invalid opcodes go directly to DONE.
REQ-016 MUL SHALL use a MUL_STAGES-deep pipelined 33x33 signed multiply with operands sign- or zero-extended per opcode: mul and mulh signed x signed; mulhsu signed x unsigned; mulhu unsigned x unsigned.
REQ-017 MUL result selection: mul SHALL return product bits [31:0]; mulh, mulhsu and mulhu SHALL return bits [63:32]. resp_valid_o SHALL first assert in cycle T+MUL_STAGES.
REQ-018 DIV SHALL perform radix-2 restoring division on operand magnitudes over exactly 32 iteration cycles, then fix signs: quotient is negative iff operand signs differ (signed ops only); remainder takes the dividend's sign. resp_valid_o SHALL first assert in cycle T+33.
REQ-019 Divide by zero (b=0) SHALL give: div/divu quotient 32'hFFFF_FFFF; rem/remu remainder = a. Response SHALL be valid at T+1.
REQ-020 Signed overflow (div/rem with a=32'h8000_0000, b=32'hFFFF_FFFF) SHALL give: div 32'h8000_0000; rem 0. Response SHALL be valid at T+1.
REQ-021 An invalid opcode SHALL return result_o=0 at T+1.
REQ-022 DONE SHALL hold resp_valid_o=1 with result_o stable until resp_ready_i=1; that edge SHALL return the FSM to IDLE. req_ready_o SHALL be high in the following cycle; there is no same-cycle re-acceptance.
REQ-023 kill_i=1 in any state SHALL force IDLE at the next edge with resp_valid_o=0 and no response. kill_i SHALL take priority over acceptance and over response completion in the same cycle.
REQ-024 result_o SHALL be 0 whenever resp_valid_o=0.

Reset
REQ-025 rst_ni=0 SHALL asynchronously force: FSM to IDLE, iteration counter to 0, all pipeline registers to 0, resp_valid_o=0, result_o=0, req_ready_o=1 (the last taking effect once rst_ni deasserts).
REQ-026 Reset asserted mid-operation SHALL discard that operation; no response SHALL appear after reset release.

Verification
REQ-027 Scenario, mul: mul a=7, b=-3 accepted at T -> resp_valid_o at T+2 (MUL_STAGES=2), result 32'hFFFF_FFEB. Scenario, mulhu: a=b=32'hFFFF_FFFF -> result 32'hFFFF_FFFE.
REQ-028 Scenario, signed division: div a=-20, b=3 -> resp_valid_o at T+33, result 32'hFFFF_FFFA; rem with the same operands -> 32'hFFFF_FFFE.
REQ-029 Scenario, special cases: divu a=5, b=0 -> result 32'hFFFF_FFFF at T+1; rem a=32'h8000_0000, b=-1 -> result 0 at T+1.
REQ-030 Scenario, back-pressure: hold resp_ready_i=0 for 10 cycles after resp_valid_o -> result_o stable and req_ready_o=0 throughout; release -> IDLE, req_ready_o=1 next cycle.
REQ-031 Scenario, kill and reset: kill_i pulsed at T+10 of a divu -> no response, req_ready_o=1 at T+11; rst_ni dropped mid-divide -> all outputs 0 immediately (req_ready_o=1 after release), no stale response after release.
REQ-032 Scenario, invalid opcode: op_i=4'hA -> result 0 at T+1. Repeat with HAVE_MUL=0 and op=mul -> result 0 at T+1.
